// File: rtl/mux_no_encoding_pkg.sv
// Shared constants and the one-hot priority grant helper for mux_no_encoding.
// Select is used directly as a one-hot vector; it is never encoded or decoded.
package mux_no_encoding_pkg;
   localparam int C_NUM_INPUTS  = 6;
   localparam int C_SEL_WIDTH   = 5;
   localparam int C_DEFAULT_IDX = 5;

   typedef logic [C_SEL_WIDTH-1:0]  sel_t;
   typedef logic [C_NUM_INPUTS-1:0] grant_t;

   // Lowest set select bit wins; the default input is granted only when no bit is set.
   function automatic grant_t f_priority_grant(input sel_t sel);
      grant_t g;
      logic   blocked;
      g       = '0;
      blocked = 1'b0;
      for (int k = 0; k < C_SEL_WIDTH; k++) begin
         g[k]    = sel[k] & ~blocked;
         blocked = blocked | sel[k];
      end
      g[C_DEFAULT_IDX] = ~blocked;
      return g;
   endfunction
endpackage

// File: rtl/mux_no_encoding_if.sv
// Bus interface for mux_no_encoding: one-hot select, six data words and the registered outputs.
interface mux_no_encoding_if
   import mux_no_encoding_pkg::*;
#(
   parameter int P_DATA_WIDTH = 8
);
   sel_t                    select;
   logic [P_DATA_WIDTH-1:0] data_in_0;
   logic [P_DATA_WIDTH-1:0] data_in_1;
   logic [P_DATA_WIDTH-1:0] data_in_2;
   logic [P_DATA_WIDTH-1:0] data_in_3;
   logic [P_DATA_WIDTH-1:0] data_in_4;
   logic [P_DATA_WIDTH-1:0] data_in_5;
   logic [P_DATA_WIDTH-1:0] data_out;
   logic                    sel_err;
   logic                    sel_err_sticky;

   modport master (
      output select, data_in_0, data_in_1, data_in_2, data_in_3, data_in_4, data_in_5,
      input  data_out, sel_err, sel_err_sticky
   );

   modport slave (
      input  select, data_in_0, data_in_1, data_in_2, data_in_3, data_in_4, data_in_5,
      output data_out, sel_err, sel_err_sticky
   );
endinterface

// File: rtl/mux_sel_checker.sv
// Multi-hot select detector: registered per-cycle error flag plus a sticky flag that only reset clears.
module mux_sel_checker
   import mux_no_encoding_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  sel_t i_select,
   output logic o_sel_err,
   output logic o_sel_err_sticky
);
   logic w_multi_hot;
   logic r_sel_err;
   logic r_sel_err_sticky;

   // Clearing the lowest set bit leaves something only if two or more bits were set.
   assign w_multi_hot = |(i_select & (i_select - sel_t'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_err        <= 1'b0;
         r_sel_err_sticky <= 1'b0;
      end else begin
         r_sel_err        <= w_multi_hot;
         r_sel_err_sticky <= r_sel_err_sticky | w_multi_hot;
      end
   end

   assign o_sel_err        = r_sel_err;
   assign o_sel_err_sticky = r_sel_err_sticky;
endmodule

// File: rtl/mux_no_encoding.sv
// Six-input registered mux driven by a one-hot select, using an AND-OR structure with a priority mask.
// Define MUX_SEL_CHECK_EN to build in multi-hot select checking; otherwise the error flags are tied low.
module mux_no_encoding
   import mux_no_encoding_pkg::*;
#(
   parameter int P_DATA_WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   mux_no_encoding_if.slave   bus
);
   grant_t                  w_grant;
   logic [P_DATA_WIDTH-1:0] w_data [C_NUM_INPUTS];
   logic [P_DATA_WIDTH-1:0] w_mux;
   logic [P_DATA_WIDTH-1:0] r_data_out;
   logic                    w_sel_err;
   logic                    w_sel_err_sticky;

   assign w_data[0] = bus.data_in_0;
   assign w_data[1] = bus.data_in_1;
   assign w_data[2] = bus.data_in_2;
   assign w_data[3] = bus.data_in_3;
   assign w_data[4] = bus.data_in_4;
   assign w_data[5] = bus.data_in_5;

   assign w_grant = f_priority_grant(bus.select);

   always_comb begin
      w_mux = '0;
      for (int k = 0; k < C_NUM_INPUTS; k++) begin
         w_mux = w_mux | ({P_DATA_WIDTH{w_grant[k]}} & w_data[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_data_out <= '0;
      else     r_data_out <= w_mux;
   end

`ifdef MUX_SEL_CHECK_EN
   mux_sel_checker u_sel_checker (
      .clk              (clk),
      .rst              (rst),
      .i_select         (bus.select),
      .o_sel_err        (w_sel_err),
      .o_sel_err_sticky (w_sel_err_sticky)
   );
`else
   assign w_sel_err        = 1'b0;
   assign w_sel_err_sticky = 1'b0;
`endif

   assign bus.data_out       = r_data_out;
   assign bus.sel_err        = w_sel_err;
   assign bus.sel_err_sticky = w_sel_err_sticky;
endmodule

// File: tb/tb_mux_no_encoding.sv
// Directed self-checking bench for mux_no_encoding; error-flag expectations follow MUX_SEL_CHECK_EN.
module tb_mux_no_encoding;
   import mux_no_encoding_pkg::*;

`ifdef MUX_SEL_CHECK_EN
   localparam logic C_CHK = 1'b1;
`else
   localparam logic C_CHK = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   mux_no_encoding_if #(.P_DATA_WIDTH(8)) bus ();

   mux_no_encoding #(.P_DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic edge_sample();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input logic [7:0] d0, d1, d2, d3, d4, d5);
      bus.data_in_0 = d0;
      bus.data_in_1 = d1;
      bus.data_in_2 = d2;
      bus.data_in_3 = d3;
      bus.data_in_4 = d4;
      bus.data_in_5 = d5;
   endtask

   logic [7:0] walk_exp [6];
   sel_t       walk_sel [6];
   logic [7:0] rd [6];
   logic       sticky_exp;

   initial begin
      n_cmp = 0;
      n_err = 0;
      sticky_exp = 1'b0;
      walk_sel[0] = 5'b00001; walk_sel[1] = 5'b00010; walk_sel[2] = 5'b00100;
      walk_sel[3] = 5'b01000; walk_sel[4] = 5'b10000; walk_sel[5] = 5'b00000;
      walk_exp[0] = 8'h10; walk_exp[1] = 8'h11; walk_exp[2] = 8'h12;
      walk_exp[3] = 8'h13; walk_exp[4] = 8'h14; walk_exp[5] = 8'h15;

      rst = 1'b1;
      set_data(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      bus.select = 5'b00001;

      // held in reset with clock running
      for (int i = 0; i < 3; i++) begin
         edge_sample();
         chk("rst_data_out", bus.data_out, 8'h00);
         chk("rst_sel_err", bus.sel_err, 1'b0);
         chk("rst_sticky", bus.sel_err_sticky, 1'b0);
      end

      #2 rst = 1'b0;
      edge_sample();
      chk("first_after_rst", bus.data_out, 8'hA5);

      set_data(8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15);
      for (int i = 0; i < 6; i++) begin
         bus.select = walk_sel[i];
         edge_sample();
         chk($sformatf("walk_%0d", i), bus.data_out, walk_exp[i]);
         chk($sformatf("walk_err_%0d", i), bus.sel_err, 1'b0);
      end

      // unchanged inputs must hold the output
      edge_sample();
      chk("hold_1", bus.data_out, 8'h15);
      edge_sample();
      chk("hold_2", bus.data_out, 8'h15);

      set_data(8'h10, 8'h3C, 8'hC3, 8'h13, 8'h14, 8'h15);
      bus.select = 5'b10110;
      edge_sample();
      sticky_exp = C_CHK;
      chk("multihot_data", bus.data_out, 8'h3C);
      chk("multihot_err", bus.sel_err, C_CHK);
      chk("multihot_sticky", bus.sel_err_sticky, sticky_exp);
      bus.select = 5'b00001;
      edge_sample();
      chk("after_mh_data", bus.data_out, 8'h10);
      chk("after_mh_err", bus.sel_err, 1'b0);
      chk("after_mh_sticky", bus.sel_err_sticky, sticky_exp);

      bus.select = 5'b11111;
      edge_sample();
      chk("all_ones_data", bus.data_out, 8'h10);
      chk("all_ones_err", bus.sel_err, C_CHK);
      chk("all_ones_sticky", bus.sel_err_sticky, sticky_exp);

      // back-to-back random one-hot / zero selects
      for (int i = 0; i < 100; i++) begin
         int idx;
         idx = $urandom_range(0, 5);
         for (int k = 0; k < 6; k++) rd[k] = 8'($urandom);
         set_data(rd[0], rd[1], rd[2], rd[3], rd[4], rd[5]);
         bus.select = (idx == 5) ? 5'b00000 : sel_t'(5'b00001 << idx);
         edge_sample();
         chk($sformatf("rand_%0d", i), bus.data_out, rd[idx]);
         chk($sformatf("rand_err_%0d", i), bus.sel_err, 1'b0);
      end
      chk("rand_sticky", bus.sel_err_sticky, sticky_exp);

      // asynchronous reset between edges
      set_data(8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05);
      bus.select = 5'b00001;
      edge_sample();
      chk("pre_async_ff", bus.data_out, 8'hFF);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_data", bus.data_out, 8'h00);
      chk("async_rst_sticky", bus.sel_err_sticky, 1'b0);
      chk("async_rst_err", bus.sel_err, 1'b0);
      #1 rst = 1'b0;
      edge_sample();
      chk("post_async_data", bus.data_out, 8'hFF);
      chk("post_async_sticky", bus.sel_err_sticky, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
